// File: rtl/tc_clk_gate_ctrl.sv
// ============================================================================
// Module   : tc_clk_gate_ctrl (with leaf cell tc_clk_gating)
// Brief    : Multi-channel clock-gating controller. One ICG per channel, each
//            driven by a request FSM with a wake-up delay and a hold window.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tc_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);
    logic en_latch_q;

    // Latch is transparent while the clock is low so enable changes never clip a high phase
    always_latch begin
        if (!clk_i) begin
            en_latch_q = en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch_q;
endmodule

module tc_clk_gate_ctrl #(
    parameter int NumChannels = 4,
    parameter int WakeCycles  = 2,
    parameter int HystCycles  = 8,
    parameter int CntWidth    = $clog2(((WakeCycles > HystCycles) ? WakeCycles : HystCycles) + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_en_i,
    input  logic [NumChannels-1:0] req_i,
    input  logic [NumChannels-1:0] force_on_i,
    output logic [NumChannels-1:0] ack_o,
    output logic [NumChannels-1:0] gate_en_o,
    output logic [NumChannels-1:0] clk_o
);
    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    localparam logic [CntWidth-1:0] c_WAKE_LOAD = CntWidth'(WakeCycles - 1);
    localparam logic [CntWidth-1:0] c_HOLD_LOAD = CntWidth'((HystCycles > 0) ? (HystCycles - 1) : 0);
    localparam logic [CntWidth-1:0] c_CNT_ONE   = CntWidth'(1);

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
        state_e              state_q, state_d;
        logic [CntWidth-1:0] cnt_q, cnt_d;
        logic                w_want;

        assign w_want = req_i[gi] | force_on_i[gi];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= S_OFF;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_OFF: begin
                    if (w_want) begin
                        state_d = S_WAKE;
                        cnt_d   = c_WAKE_LOAD;
                    end
                end
                S_WAKE: begin
                    // Wake-up always runs to completion, even if the request went away
                    if (cnt_q == '0) begin
                        if (w_want) begin
                            state_d = S_ON;
                        end else begin
                            state_d = S_HOLD;
                            cnt_d   = c_HOLD_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - c_CNT_ONE;
                    end
                end
                S_ON: begin
                    if (!w_want) begin
                        if (HystCycles == 0) begin
                            state_d = S_OFF;
                        end else begin
                            state_d = S_HOLD;
                            cnt_d   = c_HOLD_LOAD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_want) begin
                        state_d = S_ON;
                    end else if (cnt_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        cnt_d = cnt_q - c_CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            endcase
        end

        // Status outputs are pure decodes of the registered state
        assign gate_en_o[gi] = (state_q != S_OFF);
        assign ack_o[gi]     = (state_q == S_ON) || (state_q == S_HOLD);

        tc_clk_gating u_icg (
            .clk_i     (clk_i),
            .en_i      (gate_en_o[gi]),
            .test_en_i (test_en_i),
            .clk_o     (clk_o[gi])
        );
    end
endmodule

`default_nettype wire
